// File: rtl/mix_columns_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mix_columns_seq
// Purpose  : Sequential AES MixColumns engine. A 128-bit state is accepted
//            over a valid/ready handshake. One shared 32-bit column mixer is
//            applied to columns 0..3 on four consecutive cycles. The result
//            is returned over a second valid/ready handshake.
// Ports    : clk, rst_n (async, active-low)
//            in_valid / in_ready / in_data[127:0]   - input state handshake
//            in_skip (only with MIXCOL_SKIP_EN)     - pass state unchanged
//            out_valid / out_ready / out_data[127:0] - output state handshake
//            busy                                   - high while columns mix
// Config   : `define MIXCOL_SKIP_EN adds in_skip. A state accepted with
//            in_skip=1 still spends 4 BUSY cycles but is not modified
//            (AES final round).
// Layout   : column c = data[127-32c -: 32], byte 0 of a column in its MSBs.
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef MIXCOL_SKIP_EN
    input  logic         in_skip,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     col_q, col_d;
    logic [127:0]   buf_q, buf_d;
    logic [31:0]    col_in, col_out;
    logic           accept;
    logic           wb_en;

`ifdef MIXCOL_SKIP_EN
    logic           skip_q, skip_d;
    assign wb_en = ~skip_q;
`else
    assign wb_en = 1'b1;
`endif

    // in_ready depends only on state and out_ready; in_valid never feeds it.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign out_data  = buf_q;

    // Select the column currently being mixed.
    always_comb begin
        case (col_q)
            2'd0:    col_in = buf_q[127:96];
            2'd1:    col_in = buf_q[95:64];
            2'd2:    col_in = buf_q[63:32];
            default: col_in = buf_q[31:0];
        endcase
    end

    mix_columns_seq_col u_col (
        .col_i (col_in),
        .col_o (col_out)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        buf_d   = buf_q;
`ifdef MIXCOL_SKIP_EN
        skip_d  = skip_q;
`endif
        case (state_q)
            ST_BUSY: begin
                if (wb_en) begin
                    case (col_q)
                        2'd0:    buf_d[127:96] = col_out;
                        2'd1:    buf_d[95:64]  = col_out;
                        2'd2:    buf_d[63:32]  = col_out;
                        default: buf_d[31:0]   = col_out;
                    endcase
                end
                col_d = col_q + 2'd1;   // wraps to 0 after column 3
                if (col_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // A load from IDLE or a back-to-back load from DONE overrides the above.
        if (accept) begin
            buf_d   = in_data;
            col_d   = 2'd0;
            state_d = ST_BUSY;
`ifdef MIXCOL_SKIP_EN
            skip_d  = in_skip;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= 2'd0;
            buf_q   <= '0;
`ifdef MIXCOL_SKIP_EN
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
`ifdef MIXCOL_SKIP_EN
            skip_q  <= skip_d;
`endif
        end
    end

endmodule

// ============================================================================
// Module   : mix_columns_seq_col
// Purpose  : Combinational MixColumns of one 32-bit column in GF(2^8),
//            reduction polynomial 0x11B.
// Ports    : col_i[31:0] - input column, byte 0 in [31:24]
//            col_o[31:0] - mixed column, same byte order
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_seq_col (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // 3*a is written as xtime(a) ^ a.
    assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule
`default_nettype wire

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential MixColumns engine for the AES round datapath. It accepts a full 128-bit state over a valid/ready handshake and time-multiplexes one 32-bit `mix_column` instance across the four columns, one column per cycle. It returns the transformed state over a second valid/ready handshake. It sits between ShiftRows and AddRoundKey in the area-optimised round loop, trading throughput for one quarter of the MixColumns logic.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a state this cycle.
- `in_data`  in  128  input state; column c = `in_data[127-32c -: 32]`; byte 0 of each column in its MSBs.
- `out_valid`  out  1  `out_data` holds a completed state.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_data`  out  128  transformed state; same column and byte order as `in_data`.
- `busy`  out  1  high in BUSY state.

## Operation
- FSM states: IDLE, BUSY, DONE. A 2-bit column counter `col` and a 128-bit state buffer `buf` are used.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: `buf`<=`in_data`, `col`<=0, go to BUSY.
- BUSY:
  - `in_ready`=0.
  - Each cycle, column `col` of `buf` is replaced in place by `mix_column(buf column col)`, and `col` increments.
  - When `col`==3, go to DONE. `col` wraps to 0.
- DONE:
  - `out_valid`=1 and `out_data`=`buf`.
  - `in_ready`=`out_ready`, so a new state can be accepted in the same cycle the output handshake completes.
  - On `out_ready` with `in_valid`: load the new state, `col`<=0, go to BUSY (back-to-back).
  - On `out_ready` without `in_valid`: go to IDLE.
  - Without `out_ready`: stay in DONE, with `buf` and `out_data` held stable.
- `out_data` is driven from `buf` in every state. It is only meaningful while `out_valid`=1.
- Arithmetic: GF(2^8) with reduction polynomial 0x11B, computed by the shared column instance. No wider arithmetic is used.
- `in_data` is sampled only on the accepting edge. Changes on `in_data` at other times have no effect.
- Reset (asynchronous, at any time, including mid-BUSY):
  - State goes to IDLE, `col`=0, `buf`=0.
  - The partially processed state is discarded.
  - Outputs become `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=128'h0.
- Latency: with the accepting edge as E0, columns 0..3 are written on E1..E4. `out_valid` is high after E4.
- Throughput:
  - Isolated transfer: 6 cycles (IDLE accept, 4 BUSY, DONE).
  - Sustained back-to-back with `out_ready` held high: one state every 5 cycles.
- `out_valid` never deasserts without an `out_ready` handshake. `out_data` is stable while `out_valid && !out_ready`.
- `in_ready` is combinational from state and `out_ready` only. There is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `MIXCOL_SKIP_EN` defined:
  - Adds input port `in_skip` (1 bit), sampled with `in_data`.
  - A state accepted with `in_skip`=1 passes through unchanged, for the AES final round.
  - The FSM still walks BUSY for 4 cycles, so latency and throughput are identical. Column write-back is suppressed.
- `MIXCOL_SKIP_EN` undefined: no `in_skip` port. Every accepted state is transformed.

## Test plan
- Reset mid-BUSY: assert `rst_n`=0 after E2. Required: `busy`=0, `out_valid`=0, `in_ready`=1 immediately without a clock, `out_data`=0. After release, the next transfer is correct.
- FIPS-197 columns: `in_data`=128'hdb135345_f20a225c_01010101_c6c6c6c6. Required: `out_valid` rises after E4 with `out_data`=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6.
- Backpressure: `in_data`=128'hd4d4d4d5_2d26314c_00000000_ffffffff, with `out_ready`=0 for 7 cycles after `out_valid`. Required: `out_data`=128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff held stable; `in_ready`=0 throughout; a single handshake then returns to IDLE.
- Back-to-back: 3 states offered with `in_valid` held high and `out_ready`=1. Required: `out_valid` pulses spaced exactly 5 cycles, and each output matches the software model.
- Skip (with `MIXCOL_SKIP_EN`): the FIPS-197 vector with `in_skip`=1. Required: `out_data` equals `in_data` after E4. The next transfer with `in_skip`=0 is transformed normally.
